// File: rtl/binary_search_ctrl.sv
// Sequencing FSM for a binary search datapath over a synchronous RAM with 1-cycle read latency.
// Drives init/up/down strobes and reports done, found, watchdog error and the comparison count.
module binary_search_ctrl #(
  parameter int unsigned LOGN      = 5,
  parameter int unsigned MAX_STEPS = LOGN + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          fl_eq_cl,
  input  logic          A_eq_B,
  input  logic          A_gt_B,
  output logic          init_reg,
  output logic          look_up,
  output logic          look_down,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [LOGN:0] steps
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StCmp,
    StDone
  } state_e;

  localparam logic [LOGN:0] StepsMax = (LOGN + 1)'(MAX_STEPS);
  localparam logic [LOGN:0] StepOne  = (LOGN + 1)'(1);

  state_e        state_q, state_d;
  logic [LOGN:0] steps_q, steps_d;
  logic          found_q, found_d;
  logic          err_q, err_d;
  logic [LOGN:0] steps_inc;
  logic          init_raw, up_raw, down_raw;

  assign steps_inc = steps_q + StepOne;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      steps_q <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      found_q <= found_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;
    init_raw = 1'b0;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        init_raw = 1'b1;
        busy     = 1'b1;
        steps_d  = '0;
        found_d  = 1'b0;
        err_d    = 1'b0;
        state_d  = StWait;
      end
      StWait: begin
        // New loc must pass through the RAM's registered address before compare.
        busy    = 1'b1;
        state_d = StCmp;
      end
      StCmp: begin
        busy    = 1'b1;
        steps_d = steps_inc;
        if (A_eq_B) begin
          found_d = 1'b1;
          state_d = StDone;
        end else if (fl_eq_cl) begin
          found_d = 1'b0;
          state_d = StDone;
        end else if (steps_inc >= StepsMax) begin
          found_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (A_gt_B) begin
          up_raw  = 1'b1;
          state_d = StWait;
        end else begin
          down_raw = 1'b1;
          state_d  = StWait;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) state_d = StLoad;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath must never move in a reset cycle, even mid-search.
  assign init_reg  = init_raw & ~reset;
  assign look_up   = up_raw & ~reset;
  assign look_down = down_raw & ~reset;

  assign found = found_q;
  assign err   = err_q;
  assign steps = steps_q;

endmodule
